apb_req_arbiter: RTL and testbench

Two-requester arbiter and sequencer in front of the APB master's internal interface (`transfer`/`write`/`addr`/`wdata` → `ready`/`rdata`). Lets the CPU data port and a second bus user (DMA or debug) share the single APB master, one transaction at a time. It shadows the master's IDLE→SETUP→ACCESS sequence so that `ready` is only honoured in ACCESS. It also rejects addresses outside the peripheral window locally, so an unmapped access never hangs the bus.

---
 rtl/apb_arb_pkg.sv | 20 ++
 rtl/rr_pick2.sv | 21 ++
 rtl/apb_req_arbiter.sv | 151 +++++++++++++++
 tb/tb_apb_req_arbiter.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_arb_pkg.sv
// Shared types and address-window constants for the two-requester APB arbiter.
package apb_arb_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      SETUP,
      ACCESS,
      DONE
   } arb_state_e;

   localparam logic [31:0] APB_WIN_BASE = 32'h1000_0000;
   localparam logic [17:0] APB_WIN_TAG  = APB_WIN_BASE[31:14];

   // Peripheral window is 16 KiB: four 4 KiB slots starting at APB_WIN_BASE.
   function automatic logic in_window(input logic [31:0] addr);
      return addr[31:14] == APB_WIN_TAG;
   endfunction

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way winner select; `last` is the index granted most recently.
module rr_pick2 (
   input  logic       valid0,
   input  logic       valid1,
   input  logic       last,
   input  logic       rr_en,
   output logic [1:0] grant
);

   always_comb begin
      grant = 2'b00;
      if (valid0 && valid1) begin
         grant = (rr_en && !last) ? 2'b10 : 2'b01;
      end else if (valid0) begin
         grant = 2'b01;
      end else if (valid1) begin
         grant = 2'b10;
      end
   end

endmodule

// File: rtl/apb_req_arbiter.sv
// Shares one APB master between two requesters, one transaction at a time,
// shadowing the master's SETUP/ACCESS phases and rejecting unmapped addresses locally.
module apb_req_arbiter
   import apb_arb_pkg::*;
#(
   parameter bit RR_EN = 1'b1
) (
   input  logic        PCLK,
   input  logic        PRESET,
   input  logic        req0_valid,
   input  logic        req0_write,
   input  logic [31:0] req0_addr,
   input  logic [31:0] req0_wdata,
   output logic        req0_done,
   output logic        req0_err,
   output logic [31:0] req0_rdata,
   input  logic        req1_valid,
   input  logic        req1_write,
   input  logic [31:0] req1_addr,
   input  logic [31:0] req1_wdata,
   output logic        req1_done,
   output logic        req1_err,
   output logic [31:0] req1_rdata,
   output logic        m_transfer,
   output logic        m_write,
   output logic [31:0] m_addr,
   output logic [31:0] m_wdata,
   input  logic        m_ready,
   input  logic [31:0] m_rdata,
   output logic [1:0]  grant,
   output logic        busy
);

   arb_state_e  state_reg, state_next;
   logic [1:0]  grant_reg;
   logic [1:0]  pick;
   logic        last_reg;
   logic        write_reg;
   logic        err_reg;
   logic [31:0] addr_reg;
   logic [31:0] wdata_reg;
   logic [31:0] rdata0_reg;
   logic [31:0] rdata1_reg;

   logic        sel_write;
   logic [31:0] sel_addr;
   logic [31:0] sel_wdata;
   logic        sel_ok;

   rr_pick2 u_pick (
      .valid0 (req0_valid),
      .valid1 (req1_valid),
      .last   (last_reg),
      .rr_en  (RR_EN),
      .grant  (pick)
   );

   assign sel_write = pick[1] ? req1_write : req0_write;
   assign sel_addr  = pick[1] ? req1_addr  : req0_addr;
   assign sel_wdata = pick[1] ? req1_wdata : req0_wdata;
   assign sel_ok    = in_window(sel_addr);

   always_ff @(posedge PCLK or negedge PRESET) begin
      if (!PRESET) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: begin
            if (pick != 2'b00) begin
               state_next = sel_ok ? ISSUE : DONE;
            end
         end
         ISSUE:  state_next = SETUP;
         // The slave's ready may already be high here; only ACCESS honours it.
         SETUP:  state_next = ACCESS;
         ACCESS: begin
            if (m_ready) begin
               state_next = DONE;
            end
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge PCLK or negedge PRESET) begin
      if (!PRESET) begin
         grant_reg  <= 2'b00;
         last_reg   <= 1'b1;
         write_reg  <= 1'b0;
         err_reg    <= 1'b0;
         addr_reg   <= '0;
         wdata_reg  <= '0;
         rdata0_reg <= '0;
         rdata1_reg <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (pick != 2'b00) begin
                  grant_reg <= pick;
                  last_reg  <= pick[1];
                  write_reg <= sel_write;
                  addr_reg  <= sel_addr;
                  wdata_reg <= sel_wdata;
                  err_reg   <= !sel_ok;
                  // Rejected accesses return zero data without touching the master.
                  if (!sel_ok) begin
                     if (pick[0]) begin
                        rdata0_reg <= '0;
                     end else begin
                        rdata1_reg <= '0;
                     end
                  end
               end
            end
            ACCESS: begin
               if (m_ready) begin
                  if (grant_reg[0]) begin
                     rdata0_reg <= m_rdata;
                  end else begin
                     rdata1_reg <= m_rdata;
                  end
               end
            end
            DONE:    grant_reg <= 2'b00;
            default: ;
         endcase
      end
   end

   assign m_transfer = (state_reg == ISSUE);
   assign m_write    = write_reg;
   assign m_addr     = addr_reg;
   assign m_wdata    = wdata_reg;
   assign grant      = grant_reg;
   assign busy       = (state_reg != IDLE);

   assign req0_done  = (state_reg == DONE) && grant_reg[0];
   assign req1_done  = (state_reg == DONE) && grant_reg[1];
   assign req0_err   = req0_done && err_reg;
   assign req1_err   = req1_done && err_reg;
   assign req0_rdata = rdata0_reg;
   assign req1_rdata = rdata1_reg;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Scoreboard bench: drivers queue expected completions and master transfers,
// independent monitors pop and compare as the arbiter presents them.
module tb_apb_req_arbiter;

   logic        PCLK = 1'b0;
   logic        PRESET = 1'b0;
   logic        req0_valid = 1'b0, req0_write = 1'b0;
   logic [31:0] req0_addr = '0, req0_wdata = '0;
   logic        req1_valid = 1'b0, req1_write = 1'b0;
   logic [31:0] req1_addr = '0, req1_wdata = '0;
   logic        m_ready;
   logic [31:0] m_rdata;

   logic        req0_done, req0_err, req1_done, req1_err;
   logic [31:0] req0_rdata, req1_rdata;
   logic        m_transfer, m_write, busy;
   logic [31:0] m_addr, m_wdata;
   logic [1:0]  grant;

   logic        fp_req0_done, fp_req0_err, fp_req1_done, fp_req1_err;
   logic [31:0] fp_req0_rdata, fp_req1_rdata;
   logic        fp_m_transfer, fp_m_write, fp_busy;
   logic [31:0] fp_m_addr, fp_m_wdata;
   logic [1:0]  fp_grant;

   always #5 PCLK = ~PCLK;

   apb_req_arbiter #(.RR_EN(1'b1)) dut (
      .PCLK(PCLK), .PRESET(PRESET),
      .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr),
      .req0_wdata(req0_wdata), .req0_done(req0_done), .req0_err(req0_err),
      .req0_rdata(req0_rdata),
      .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
      .req1_wdata(req1_wdata), .req1_done(req1_done), .req1_err(req1_err),
      .req1_rdata(req1_rdata),
      .m_transfer(m_transfer), .m_write(m_write), .m_addr(m_addr), .m_wdata(m_wdata),
      .m_ready(m_ready), .m_rdata(m_rdata), .grant(grant), .busy(busy)
   );

   // Fixed-priority instance runs in lockstep on the same inputs.
   apb_req_arbiter #(.RR_EN(1'b0)) dut_fp (
      .PCLK(PCLK), .PRESET(PRESET),
      .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr),
      .req0_wdata(req0_wdata), .req0_done(fp_req0_done), .req0_err(fp_req0_err),
      .req0_rdata(fp_req0_rdata),
      .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
      .req1_wdata(req1_wdata), .req1_done(fp_req1_done), .req1_err(fp_req1_err),
      .req1_rdata(fp_req1_rdata),
      .m_transfer(fp_m_transfer), .m_write(fp_m_write), .m_addr(fp_m_addr),
      .m_wdata(fp_m_wdata), .m_ready(m_ready), .m_rdata(m_rdata),
      .grant(fp_grant), .busy(fp_busy)
   );

   typedef struct {
      int          idx;
      bit          err;
      logic [31:0] rdata;
      int          t;
   } done_t;

   typedef struct {
      bit          wr;
      logic [31:0] a;
      logic [31:0] d;
      int          t;
   } xfer_t;

   done_t       done_q[$];
   xfer_t       xfer_q[$];
   int          checks = 0;
   int          failures = 0;
   int          cyc = 0;
   int          done_seen = 0;
   int          fp_count = 0;
   bit          fp_phase = 1'b0;
   int          slave_ws = 0;
   logic [31:0] slave_rd = '0;

   always @(posedge PCLK) cyc++;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", name, got, exp, cyc);
      end
   endtask

   // Slave model: ready high through SETUP (must be ignored), then ws low ACCESS cycles.
   initial begin : slave
      int          ws;
      logic [31:0] rd;
      m_ready = 1'b0;
      m_rdata = '0;
      forever begin
         @(negedge PCLK);
         if (PRESET && m_transfer) begin
            ws = slave_ws;
            rd = slave_rd;
            @(negedge PCLK);
            m_ready = 1'b1;
            m_rdata = (ws == 0) ? rd : ~rd;
            @(negedge PCLK);
            if (ws > 0) begin
               m_ready = 1'b0;
               repeat (ws) @(negedge PCLK);
               m_ready = 1'b1;
               m_rdata = rd;
            end
            @(negedge PCLK);
            m_ready = 1'b0;
         end
      end
   end

   always @(negedge PCLK) begin : mon_done
      done_t e;
      if (PRESET && (req0_done || req1_done)) begin
         done_seen++;
         if (done_q.size() == 0) begin
            chk("unexpected_done", {req1_done, req0_done}, 2'b00);
         end else begin
            e = done_q.pop_front();
            chk("done_port", {req1_done, req0_done}, (e.idx == 1) ? 2'b10 : 2'b01);
            chk("done_cycle", cyc, e.t);
            chk("done_err", (e.idx == 1) ? req1_err : req0_err, e.err);
            chk("done_rdata", (e.idx == 1) ? req1_rdata : req0_rdata, e.rdata);
            chk("done_grant", grant, (e.idx == 1) ? 2'b10 : 2'b01);
         end
      end
   end

   always @(negedge PCLK) begin : mon_xfer
      xfer_t cur;
      bit    in_txn;
      if (!PRESET) begin
         in_txn = 1'b0;
      end else begin
         if (m_transfer) begin
            if (in_txn || xfer_q.size() == 0) begin
               chk("unexpected_transfer", m_transfer, 1'b0);
            end else begin
               cur = xfer_q.pop_front();
               in_txn = 1'b1;
               chk("xfer_cycle", cyc, cur.t);
            end
         end
         if (in_txn) begin
            chk("m_addr_stable", m_addr, cur.a);
            chk("m_wdata_stable", m_wdata, cur.d);
            chk("m_write_stable", m_write, cur.wr);
            if (req0_done || req1_done) in_txn = 1'b0;
         end
      end
   end

   always @(negedge PCLK) begin
      if (fp_phase && (fp_req0_done || fp_req1_done)) begin
         fp_count++;
         chk("fp_grant", fp_grant, 2'b01);
         chk("fp_done_port", {fp_req1_done, fp_req0_done}, 2'b01);
      end
   end

   task automatic do_req(input int idx, input bit wr, input logic [31:0] a,
                         input logic [31:0] d, input int ws, input logic [31:0] rd,
                         input bit err);
      bit got;
      int t;
      @(negedge PCLK);
      t = cyc;
      slave_ws = ws;
      slave_rd = rd;
      if (idx == 0) begin
         req0_write = wr; req0_addr = a; req0_wdata = d; req0_valid = 1'b1;
      end else begin
         req1_write = wr; req1_addr = a; req1_wdata = d; req1_valid = 1'b1;
      end
      done_q.push_back(done_t'{idx, err, err ? 32'h0 : rd, t + (err ? 1 : 4 + ws)});
      if (!err) xfer_q.push_back(xfer_t'{wr, a, d, t + 1});
      got = 1'b0;
      for (int k = 0; k < 40 && !got; k++) begin
         @(negedge PCLK);
         // Requester-side changes mid-transaction must not reach the master.
         if (idx == 0) begin
            req0_addr = ~a; req0_wdata = ~d;
            got = req0_done;
         end else begin
            req1_addr = ~a; req1_wdata = ~d;
            got = req1_done;
         end
      end
      chk("req_completed", got, 1'b1);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_busy_grant"}, {busy, grant}, 3'b000);
      chk({tag, "_m_ctrl"}, {m_transfer, m_write}, 2'b00);
      chk({tag, "_m_addr_wdata"}, {m_addr, m_wdata}, 64'h0);
      chk({tag, "_req0"}, {req0_done, req0_err, req0_rdata}, 34'h0);
      chk({tag, "_req1"}, {req1_done, req1_err, req1_rdata}, 34'h0);
   endtask

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      int t0;
      int ds;
      repeat (3) @(posedge PCLK);
      @(negedge PCLK);
      chk_all_zero("reset");
      #2 PRESET = 1'b1;

      // Both requesters held valid: round-robin 01,10,01,10 starting from last=1.
      @(negedge PCLK);
      t0 = cyc;
      slave_ws = 0;
      slave_rd = 32'hCAFE_0001;
      req0_write = 1'b1; req0_addr = 32'h1000_0010; req0_wdata = 32'hA5A5_0001;
      req1_write = 1'b0; req1_addr = 32'h1000_3FFC; req1_wdata = 32'h0;
      req0_valid = 1'b1; req1_valid = 1'b1;
      fp_phase = 1'b1;
      for (int i = 0; i < 4; i++) begin
         done_q.push_back(done_t'{i % 2, 1'b0, 32'hCAFE_0001, t0 + 4 + 5 * i});
         if (i % 2 == 0)
            xfer_q.push_back(xfer_t'{1'b1, 32'h1000_0010, 32'hA5A5_0001, t0 + 1 + 5 * i});
         else
            xfer_q.push_back(xfer_t'{1'b0, 32'h1000_3FFC, 32'h0, t0 + 1 + 5 * i});
      end
      while (cyc < t0 + 19) @(negedge PCLK);
      req0_valid = 1'b0; req1_valid = 1'b0;
      @(negedge PCLK);
      fp_phase = 1'b0;
      chk("fp_done_count", fp_count, 4);

      do_req(0, 1'b1, 32'h1000_1004, 32'hDEAD_BEEF, 0, 32'h0000_5555, 1'b0);
      do_req(1, 1'b0, 32'h1000_2000, 32'h0, 3, 32'h1234_5678, 1'b0);
      do_req(0, 1'b0, 32'h2000_0000, 32'h0, 0, 32'h0, 1'b1);
      chk("req1_rdata_hold", req1_rdata, 32'h1234_5678);
      do_req(1, 1'b0, 32'h1000_4000, 32'h0, 0, 32'h0, 1'b1);
      do_req(0, 1'b1, 32'h0FFF_FFFC, 32'h9, 0, 32'h0, 1'b1);
      do_req(1, 1'b1, 32'h1000_3FFF, 32'h1, 1, 32'h0000_0077, 1'b0);

      // Reset in the middle of a long ACCESS phase.
      @(negedge PCLK);
      t0 = cyc;
      slave_ws = 8;
      slave_rd = 32'h1111_2222;
      req0_write = 1'b0; req0_addr = 32'h1000_0100; req0_wdata = 32'h0;
      req0_valid = 1'b1;
      xfer_q.push_back(xfer_t'{1'b0, 32'h1000_0100, 32'h0, t0 + 1});
      while (cyc < t0 + 4) @(negedge PCLK);
      chk("pre_reset_busy", busy, 1'b1);
      #2 PRESET = 1'b0;
      req0_valid = 1'b0;
      #1 chk_all_zero("midreset");
      ds = done_seen;
      @(negedge PCLK);
      @(negedge PCLK);
      #2 PRESET = 1'b1;
      while (cyc < t0 + 16) @(negedge PCLK);
      chk("no_done_after_reset", done_seen - ds, 0);

      do_req(0, 1'b0, 32'h1000_0200, 32'h0, 0, 32'h0F0F_0F0F, 1'b0);

      repeat (3) @(negedge PCLK);
      chk("done_queue_drained", done_q.size(), 0);
      chk("xfer_queue_drained", xfer_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
